// File: rtl/fakeram45_64x21_ctrl.sv
// Initiator-side controller for the 64x21 fakeram45 macro: zero-fills the array after reset,
// then maps valid/ready requests onto single-cycle macro accesses with a read-response FIFO.
module fakeram45_64x21_ctrl #(
  parameter int BITS       = 21,
  parameter int WORD_DEPTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BITS-1:0]       req_wdata,
  input  logic [BITS-1:0]       req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BITS-1:0]       rsp_rdata,
  output logic                  init_done,
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [BITS-1:0]       ram_wd,
  output logic [BITS-1:0]       ram_wmask,
  input  logic [BITS-1:0]       ram_rd
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int OW = $clog2(RSP_DEPTH + 1);
  localparam int CW = OW + 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);
  localparam logic [PW-1:0]         LAST_PTR  = PW'(RSP_DEPTH - 1);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [BITS-1:0]       fifo_mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [OW-1:0]         occ;
  logic                  rd_pend;

  logic in_run;
  logic push;
  logic pop;
  logic room;
  logic accept;
  logic [CW-1:0] committed;
  logic [CW-1:0] limit;

  assign in_run    = (state == ST_RUN);
  assign init_done = in_run;
  assign rsp_valid = (occ != '0);
  assign rsp_rdata = fifo_mem[rd_ptr];
  assign pop       = rsp_valid & rsp_ready;
  assign push      = rd_pend;

  // A read may only launch if its response is guaranteed a FIFO slot, counting the
  // read already in the macro and any entry leaving this cycle.
  always_comb begin
    committed = CW'(occ) + CW'(rd_pend);
    limit     = CW'(RSP_DEPTH) + CW'(pop);
    room      = (committed < limit);
  end

  assign req_ready = in_run & (req_we | room);
  assign accept    = req_valid & req_ready;

  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wd    = '0;
    ram_wmask = '0;
    if (!rst) begin
      if (!in_run) begin
        ram_ce    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = fill_addr;
        ram_wmask = '1;
      end else if (accept) begin
        ram_ce    = 1'b1;
        ram_we    = req_we;
        ram_addr  = req_addr;
        ram_wd    = req_wdata;
        ram_wmask = req_wmask;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      fill_addr <= '0;
    end else if (state == ST_INIT) begin
      fill_addr <= fill_addr + 1'b1;
      if (fill_addr == LAST_ADDR) begin
        state <= ST_RUN;
      end
    end
  end

  // rd_pend marks the one cycle in which ram_rd carries data for an accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= accept & ~req_we;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= ram_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule
